hazard_scoreboard: RTL

Parametrised successor to the single-cycle load-use hazard detector. Tracks every outstanding variable-latency load in a per-register scoreboard and drives stall, bubble and flush controls for the IF/ID and ID/EX pipeline registers. Adds a branch-flush sequencer, a fence drain mode, an outstanding-load limit and a stall performance counter. Sits in the ID stage beside the register file; forwarding of ALU results is handled elsewhere.

---
 rtl/hazard_pkg.sv | 14 +
 rtl/sb_regfile_bits.sv | 58 +++++
 rtl/hazard_scoreboard.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and defaults for the ID-stage hazard scoreboard.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } hz_state_e;

  localparam int NREG_DEF  = 32;
  localparam int REG_W_DEF = 5;
  localparam int X0        = 0;

endpackage

// File: rtl/sb_regfile_bits.sv
// Per-register pending bits for outstanding loads. If a register is set and
// cleared in the same cycle, the set wins. Bad responses raise a sticky error.
module sb_regfile_bits
  import hazard_pkg::*;
#(
  parameter int NREG  = NREG_DEF,
  parameter int REG_W = REG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_rd,
  input  logic             clr_en,
  input  logic [REG_W-1:0] clr_rd,
  output logic [NREG-1:0]  pending,
  output logic             set_fire,
  output logic             clr_fire,
  output logic             resp_err
);

  localparam logic [REG_W-1:0] X0_IDX = REG_W'(X0);

  logic [NREG-1:0] pending_q, pending_d;
  logic            resp_err_q, resp_err_d;

  assign set_fire = set_en && (set_rd != X0_IDX);
  // A clear is only valid against a pending, non-zero register.
  assign clr_fire = clr_en && (clr_rd != X0_IDX) && pending_q[clr_rd];

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_bit
      if (gi == X0) begin : g_x0
        assign pending_d[gi] = 1'b0;
      end else begin : g_reg
        logic hit_set, hit_clr;
        assign hit_set       = set_fire && (set_rd == REG_W'(gi));
        assign hit_clr       = clr_fire && (clr_rd == REG_W'(gi));
        assign pending_d[gi] = hit_set | (pending_q[gi] & ~hit_clr);
      end
    end
  endgenerate

  assign resp_err_d = resp_err_q | (clr_en & ~clr_fire);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q  <= '0;
      resp_err_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      resp_err_q <= resp_err_d;
    end
  end

  assign pending  = pending_q;
  assign resp_err = resp_err_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard control: load scoreboard, branch-flush sequencer,
// fence drain, outstanding-load limit and stall performance counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG      = NREG_DEF,
  parameter int REG_W     = REG_W_DEF,
  parameter int MAX_OUT   = 4,
  parameter int OUT_W     = 3,
  parameter int FLUSH_CYC = 2,
  parameter int PERF_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs1,
  input  logic [REG_W-1:0]  id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_fence,
  input  logic              mem_resp_valid,
  input  logic [REG_W-1:0]  mem_resp_rd,
  input  logic              branch_taken,
  output logic              stall,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_bubble,
  output logic              if_id_flush,
  output logic [NREG-1:0]   pending,
  output logic [OUT_W-1:0]  outstanding,
  output logic              resp_err,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam int               FC_W    = $clog2(FLUSH_CYC + 1);
  localparam logic [REG_W-1:0] X0_IDX  = REG_W'(X0);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUT);

  hz_state_e         state_q, state_d;
  logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

  logic raw, waw, full, haz, fence_wait, issue;
  logic set_en, set_fire, clr_fire;

  sb_regfile_bits #(
    .NREG  (NREG),
    .REG_W (REG_W)
  ) u_bits (
    .clk      (clk),
    .rst      (rst),
    .set_en   (set_en),
    .set_rd   (id_rd),
    .clr_en   (mem_resp_valid),
    .clr_rd   (mem_resp_rd),
    .pending  (pending),
    .set_fire (set_fire),
    .clr_fire (clr_fire),
    .resp_err (resp_err)
  );

  assign raw  = (id_rs1_used && pending[id_rs1] && (id_rs1 != X0_IDX)) ||
                (id_rs2_used && pending[id_rs2] && (id_rs2 != X0_IDX));
  assign waw  = id_regwrite && (id_rd != X0_IDX) && pending[id_rd];
  assign full = id_memread && (out_q == OUT_MAX);
  assign haz  = id_valid && (raw || waw || full);
  // The fence is held in ID from the moment it sees loads in flight, so it
  // issues only once the drain completes.
  assign fence_wait = id_valid && id_fence && (out_q != '0);

  always_comb begin
    stall = 1'b0;
    unique case (state_q)
      RUN:     stall = haz | fence_wait;
      DRAIN:   stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  assign issue  = id_valid && !stall && (state_q == RUN);
  assign set_en = issue && id_memread && id_regwrite;

  always_comb begin
    out_d = out_q;
    if (set_fire && !clr_fire && (out_q != OUT_MAX)) begin
      out_d = out_q + OUT_W'(1);
    end else if (!set_fire && clr_fire && (out_q != '0)) begin
      out_d = out_q - OUT_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    unique case (state_q)
      RUN: begin
        if (fence_wait) state_d = DRAIN;
      end
      FLUSH: begin
        flush_cnt_d = flush_cnt_q - FC_W'(1);
        if (flush_cnt_q <= FC_W'(1)) state_d = RUN;
      end
      DRAIN: begin
        if (out_d == '0) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    // A taken branch overrides everything and restarts the flush window.
    if (branch_taken) begin
      state_d     = FLUSH;
      flush_cnt_d = FC_W'(FLUSH_CYC);
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + PERF_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
      out_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      out_q       <= out_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pc_write     = ~stall;
  assign if_id_write  = ~stall;
  assign if_id_flush  = (state_q == FLUSH);
  assign id_ex_bubble = stall | (state_q == FLUSH);
  assign outstanding  = out_q;
  assign stall_cycles = stall_cnt_q;

endmodule
